// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU pipeline with flag register and optional saturation
//
// Purpose: accepts one ALU request per cycle into S1, computes the result
// combinationally between S1 and S2, and presents it in S2 with a
// valid/ready handshake. A {N,Z,C,V} flag register is updated when an op
// moves from S1 to S2, so carry-chained ops issued back to back see the
// carry produced by the op ahead of them.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            request handshake
//   op, operand_a, operand_b     opcode and operands
//   shift_c                      shifter carry, C for logical ops
//   set_flags, tag_in            flag update request, destination tag
//   out_valid/out_ready          result handshake
//   result, result_wb, tag_out   result, writeback enable, tag
//   nzcv                         flag register
//   flags_load, flags_in         direct flag register load
//   busy                         any stage occupied
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int SAT_EN = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              shift_c,
  input  logic              set_flags,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_wb,
  output logic [TAG_W-1:0]  tag_out,
  output logic [3:0]        nzcv,
  input  logic              flags_load,
  input  logic [3:0]        flags_in,
  output logic              busy
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // S1 request registers
  logic              r_s1_valid;
  logic [3:0]        r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic              r_s1_shc;
  logic              r_s1_sf;
  logic [TAG_W-1:0]  r_s1_tag;

  // S2 result registers
  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_result_wb;
  logic [TAG_W-1:0]  r_tag_out;
  logic [3:0]        r_nzcv;

  logic              w_advance;
  logic              w_test;
  logic              w_arith;
  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  logic              w_cin;
  logic [DATA_W:0]   w_sum;
  logic              w_ovf;
  logic [DATA_W-1:0] w_logic;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;
  logic [3:0]        w_nzcv_new;

  assign w_advance = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_advance;
  assign busy      = r_s1_valid || r_out_valid;

  assign w_test = (r_s1_op == OP_TST) || (r_s1_op == OP_TEQ) ||
                  (r_s1_op == OP_CMP) || (r_s1_op == OP_CMN);

  // Every arithmetic op is folded into x + y + cin: subtraction uses the
  // inverted subtrahend, so the adder carry-out is directly "not borrow".
  always_comb begin
    w_x     = r_s1_a;
    w_y     = r_s1_b;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    case (r_s1_op)
      OP_ADD, OP_CMN: ;
      OP_ADC:         w_cin = r_nzcv[1];
      OP_SUB, OP_CMP: begin w_y = ~r_s1_b; w_cin = 1'b1; end
      OP_SBC:         begin w_y = ~r_s1_b; w_cin = r_nzcv[1]; end
      OP_RSB:         begin w_x = r_s1_b; w_y = ~r_s1_a; w_cin = 1'b1; end
      OP_RSC:         begin w_x = r_s1_b; w_y = ~r_s1_a; w_cin = r_nzcv[1]; end
      default:        w_arith = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{DATA_W{1'b0}}, w_cin};
  // Overflow: both addends share a sign that the sum does not.
  assign w_ovf = (w_x[DATA_W-1] == w_y[DATA_W-1]) &&
                 (w_sum[DATA_W-1] != w_x[DATA_W-1]);

  always_comb begin
    w_logic = '0;
    case (r_s1_op)
      OP_AND, OP_TST: w_logic = r_s1_a & r_s1_b;
      OP_EOR, OP_TEQ: w_logic = r_s1_a ^ r_s1_b;
      OP_ORR:         w_logic = r_s1_a | r_s1_b;
      OP_MOV:         w_logic = r_s1_b;
      OP_BIC:         w_logic = r_s1_a & ~r_s1_b;
      OP_MVN:         w_logic = ~r_s1_b;
      default:        w_logic = '0;
    endcase
  end

  // On overflow the true result has the sign of x, which picks the clamp.
  always_comb begin
    w_res = w_logic;
    if (w_arith) begin
      if ((SAT_EN != 0) && w_ovf && !w_test) begin
        w_res = w_x[DATA_W-1] ? SAT_MIN : SAT_MAX;
      end else begin
        w_res = w_sum[DATA_W-1:0];
      end
    end
  end

  assign w_c        = w_arith ? w_sum[DATA_W] : r_s1_shc;
  assign w_v        = w_arith ? w_ovf : r_nzcv[0];
  assign w_nzcv_new = {w_res[DATA_W-1], (w_res == '0), w_c, w_v};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_shc   <= 1'b0;
      r_s1_sf    <= 1'b0;
      r_s1_tag   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op  <= op;
        r_s1_a   <= operand_a;
        r_s1_b   <= operand_b;
        r_s1_shc <= shift_c;
        r_s1_sf  <= set_flags;
        r_s1_tag <= tag_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_wb <= 1'b0;
      r_tag_out   <= '0;
    end else if (w_advance) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_result_wb <= !w_test;
      r_tag_out   <= r_s1_tag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A direct load takes priority over an update from the advancing op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nzcv <= 4'b0000;
    end else if (flags_load) begin
      r_nzcv <= flags_in;
    end else if (w_advance && (r_s1_sf || w_test)) begin
      r_nzcv <= w_nzcv_new;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_wb = r_result_wb;
  assign tag_out   = r_tag_out;
  assign nzcv      = r_nzcv;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (SAT_EN=0 and SAT_EN=1 instances)
module tb_alu_pipe;

  typedef struct {
    logic [31:0] res;
    logic        wb;
    logic [3:0]  nzcv;
    logic [3:0]  tag;
  } exp_t;

  localparam logic [3:0] ADD = 4'd4, ADC = 4'd5, SUB = 4'd2, CMP = 4'd10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, shift_c, set_flags, out_ready, flags_load;
  logic [3:0]  op, tag_in, flags_in;
  logic [31:0] operand_a, operand_b;

  logic        in_ready, out_valid, result_wb, busy;
  logic [31:0] result;
  logic [3:0]  tag_out, nzcv;
  logic        s_in_ready, s_out_valid, s_result_wb, s_busy;
  logic [31:0] s_result;
  logic [3:0]  s_tag_out, s_nzcv;

  int   tests, fails;
  exp_t q0[$], qs[$];
  logic [3:0] mf0, mfs;
  bit   acc;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_W(32), .TAG_W(4), .SAT_EN(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .shift_c(shift_c),
    .set_flags(set_flags), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_wb(result_wb),
    .tag_out(tag_out), .nzcv(nzcv), .flags_load(flags_load),
    .flags_in(flags_in), .busy(busy));

  alu_pipe #(.DATA_W(32), .TAG_W(4), .SAT_EN(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .shift_c(shift_c),
    .set_flags(set_flags), .tag_in(tag_in), .out_valid(s_out_valid),
    .out_ready(out_ready), .result(s_result), .result_wb(s_result_wb),
    .tag_out(s_tag_out), .nzcv(s_nzcv), .flags_load(flags_load),
    .flags_in(flags_in), .busy(s_busy));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: signed/unsigned integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic shc, input logic sf, input logic sat,
                                 input logic [3:0] f);
    exp_t   e;
    longint ua, ub, sa, sb, u, s, ci;
    bit     arith, test, c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ci = longint'(f[1]);
    arith = 1; test = (o >= 4'd8) && (o <= 4'd11);
    u = 0; s = 0; c = 0; v = f[0];
    case (o)
      4'd4, 4'd11: begin u = ua + ub;          s = sa + sb;          c = (u >= 64'h1_0000_0000); end
      4'd5:        begin u = ua + ub + ci;     s = sa + sb + ci;     c = (u >= 64'h1_0000_0000); end
      4'd2, 4'd10: begin u = ua - ub;          s = sa - sb;          c = (u >= 0); end
      4'd6:        begin u = ua - ub - (1-ci); s = sa - sb - (1-ci); c = (u >= 0); end
      4'd3:        begin u = ub - ua;          s = sb - sa;          c = (u >= 0); end
      4'd7:        begin u = ub - ua - (1-ci); s = sb - sa - (1-ci); c = (u >= 0); end
      default: arith = 0;
    endcase
    if (arith) begin
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      e.res = u[31:0];
      if (sat && v && !test) e.res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else begin
      c = shc;
      case (o)
        4'd0, 4'd8: e.res = a & b;
        4'd1, 4'd9: e.res = a ^ b;
        4'd12:      e.res = a | b;
        4'd13:      e.res = b;
        4'd14:      e.res = a & ~b;
        default:    e.res = ~b;
      endcase
    end
    e.wb   = !test;
    e.nzcv = (sf || test) ? {e.res[31], (e.res == 32'd0), c, v} : f;
    e.tag  = 4'd0;
    return e;
  endfunction

  // One clock: sample handshakes #1 after the negedge, update model, advance.
  task automatic step(output bit accepted);
    exp_t e;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("ret_pending", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("ret_result", 64'(result), 64'(e.res));
        chk("ret_wb", 64'(result_wb), 64'(e.wb));
        chk("ret_tag", 64'(tag_out), 64'(e.tag));
      end
    end
    if (s_out_valid && out_ready) begin
      chk("sat_ret_pending", 64'(qs.size() != 0), 64'd1);
      if (qs.size() != 0) begin
        e = qs.pop_front();
        chk("sat_ret_result", 64'(s_result), 64'(e.res));
        chk("sat_ret_tag", 64'(s_tag_out), 64'(e.tag));
      end
    end
    if (accepted) begin
      e = model(op, operand_a, operand_b, shift_c, set_flags, 1'b0, mf0);
      mf0 = e.nzcv; e.tag = tag_in; q0.push_back(e);
      e = model(op, operand_a, operand_b, shift_c, set_flags, 1'b1, mfs);
      mfs = e.nzcv; e.tag = tag_in; qs.push_back(e);
    end
    if (flags_load) begin
      mf0 = flags_in; mfs = flags_in;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic sc, input logic sf, input logic [3:0] t);
    op = o; operand_a = a; operand_b = b; shift_c = sc; set_flags = sf; tag_in = t;
  endtask

  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic sc, input logic sf, input logic [3:0] t);
    bit ok;
    ok = 0;
    set_in(o, a, b, sc, sf, t);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(ok);
      if (ok) break;
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    bit unused;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!busy && !s_busy) break;
      step(unused);
    end
    chk("drain_idle", 64'(busy || s_busy), 64'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tests = 0; fails = 0; mf0 = 4'd0; mfs = 4'd0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flags_load = 1'b0; flags_in = 4'd0;
    set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_nzcv", 64'(nzcv), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_result_wb", 64'(result_wb), 64'd0);
    chk("rst_tag_out", 64'(tag_out), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // carry chain: ADD then ADC back to back
    out_ready = 1'b1;
    set_in(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 4'd1);
    in_valid = 1'b1;
    step(acc);
    chk("chain_acc_add", 64'(acc), 64'd1);
    set_in(ADC, 32'd0, 32'd0, 1'b0, 1'b1, 4'd2);
    step(acc);
    chk("chain_acc_adc", 64'(acc), 64'd1);
    chk("chain_add_valid", 64'(out_valid), 64'd1);
    chk("chain_add_result", 64'(result), 64'h0);
    chk("chain_add_nzcv", 64'(nzcv), 64'b0110);
    in_valid = 1'b0;
    step(acc);
    chk("chain_adc_result", 64'(result), 64'h1);
    chk("chain_adc_nzcv", 64'(nzcv), 64'b0000);
    drain();

    // signed overflow, plain and saturating
    send(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 4'd4);
    drain();
    chk("ovf_result", 64'(result), 64'h8000_0000);
    chk("ovf_nzcv", 64'(nzcv), 64'b1001);
    chk("sat_result", 64'(s_result), 64'h7FFF_FFFF);
    chk("sat_nzcv", 64'(s_nzcv), 64'b0001);

    // SUB writes back, CMP updates flags without set_flags
    send(SUB, 32'd5, 32'd5, 1'b0, 1'b1, 4'd5);
    drain();
    chk("sub_result", 64'(result), 64'h0);
    chk("sub_wb", 64'(result_wb), 64'd1);
    chk("sub_nzcv", 64'(nzcv), 64'b0110);
    send(CMP, 32'd3, 32'd5, 1'b0, 1'b0, 4'd6);
    drain();
    chk("cmp_wb", 64'(result_wb), 64'd0);
    chk("cmp_nzcv", 64'(nzcv), 64'b1000);

    // backpressure: two accepted, third stalls, then all retire in order
    out_ready = 1'b0;
    send(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 4'd7);
    send(ADC, 32'd0, 32'd0, 1'b0, 1'b1, 4'd8);
    set_in(ADC, 32'd0, 32'd0, 1'b0, 1'b1, 4'd9);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("bp_third_blocked", 64'(acc), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_result", 64'(result), 64'h0);
      chk("bp_hold_tag", 64'(tag_out), 64'h7);
    end
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(ADC, 32'd0, 32'd0, 1'b0, 1'b1, 4'd9);
    drain();
    chk("bp_final_nzcv", 64'(nzcv), 64'b0100);
    chk("bp_final_nzcv_model", 64'(nzcv), 64'(mf0));

    // flags_load on the same edge as a flag update wins
    send(ADD, 32'd1, 32'd1, 1'b0, 1'b1, 4'd10);
    flags_load = 1'b1; flags_in = 4'b1111;
    step(acc);
    flags_load = 1'b0;
    chk("fload_nzcv", 64'(nzcv), 64'b1111);
    chk("fload_result", 64'(result), 64'h2);
    drain();

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(CMP, 32'd3, 32'd5, 1'b0, 1'b0, 4'd11);
    send(ADD, 32'd1, 32'd2, 1'b0, 1'b1, 4'd12);
    chk("pre_rst_nzcv", 64'(nzcv), 64'b1000);
    set_in(ADD, 32'd9, 32'd9, 1'b0, 1'b1, 4'd13);
    in_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_nzcv", 64'(nzcv), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_sat_nzcv", 64'(s_nzcv), 64'd0);
    q0.delete(); qs.delete(); mf0 = 4'd0; mfs = 4'd0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in(4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step(acc);
    end
    drain();
    chk("rand_final_nzcv", 64'(nzcv), 64'(mf0));
    chk("rand_final_sat_nzcv", 64'(s_nzcv), 64'(mfs));
    chk("rand_queue_empty", 64'(q0.size() + qs.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
